// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - multi-cycle execute-stage ALU with start/busy/done/cancel handshake
// Results are computed at accept and held in a pending register until the latency counter expires.
module iter_alu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             overflow
);

  localparam int SW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [SW:0] WFULL = WIDTH[SW:0];

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [15:0]      cnt_q;
  logic [WIDTH-1:0] res_pend_q, hi_pend_q, result_q, hi_q;
  logic             ovf_pend_q, ovf_q, done_q;

  logic [WIDTH-1:0]   res_d, hi_d;
  logic               ovf_d;
  logic [15:0]        len_d;
  logic [SW-1:0]      sh;
  logic [SW:0]        inv_sh, pc;
  logic [WIDTH:0]     add_ext, sub_ext;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   a_abs, b_abs, q_abs, r_abs, q_u, r_u;

  always_comb begin
    sh      = src_b[SW-1:0];
    inv_sh  = WFULL - {1'b0, sh};
    add_ext = {src_a[MSB], src_a} + {src_b[MSB], src_b};
    sub_ext = {src_a[MSB], src_a} - {src_b[MSB], src_b};
    prod_s  = {{WIDTH{src_a[MSB]}}, src_a} * {{WIDTH{src_b[MSB]}}, src_b};
    prod_u  = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
    // Signed divide works on magnitudes; MIN/-1 falls out as MIN with zero remainder.
    a_abs   = src_a[MSB] ? -src_a : src_a;
    b_abs   = src_b[MSB] ? -src_b : src_b;
    q_abs   = a_abs / b_abs;
    r_abs   = a_abs % b_abs;
    q_u     = src_a / src_b;
    r_u     = src_a % src_b;
    pc      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + {{SW{1'b0}}, src_a[i]};
    end

    res_d = '0;
    hi_d  = '0;
    ovf_d = 1'b0;
    len_d = 16'd1;
    case (op)
      4'd0: begin res_d = add_ext[MSB:0]; ovf_d = add_ext[WIDTH] ^ add_ext[MSB]; end
      4'd1: begin res_d = sub_ext[MSB:0]; ovf_d = sub_ext[WIDTH] ^ sub_ext[MSB]; end
      4'd2: res_d = src_a & src_b;
      4'd3: res_d = src_a | src_b;
      4'd4: res_d = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'd5: res_d = {{(WIDTH-1){1'b0}}, src_a < src_b};
      4'd6: res_d = src_a << sh;
      4'd7: res_d = (src_a << sh) | (src_a >> inv_sh);
      4'd8: res_d = (src_a >> sh) | (src_a << inv_sh);
      4'd9: res_d = {{(WIDTH-SW-1){1'b0}}, pc};
      4'd10: begin res_d = prod_s[MSB:0]; hi_d = prod_s[2*WIDTH-1:WIDTH]; len_d = 16'(MUL_CYCLES); end
      4'd11: begin res_d = prod_u[MSB:0]; hi_d = prod_u[2*WIDTH-1:WIDTH]; len_d = 16'(MUL_CYCLES); end
      4'd12: begin
        len_d = 16'(DIV_CYCLES);
        if (src_b == '0) begin
          res_d = '1;
          hi_d  = src_a;
        end else begin
          res_d = (src_a[MSB] ^ src_b[MSB]) ? -q_abs : q_abs;
          hi_d  = src_a[MSB] ? -r_abs : r_abs;
        end
      end
      4'd13: begin
        len_d = 16'(DIV_CYCLES);
        if (src_b == '0) begin
          res_d = '1;
          hi_d  = src_a;
        end else begin
          res_d = q_u;
          hi_d  = r_u;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      res_pend_q <= '0;
      hi_pend_q  <= '0;
      ovf_pend_q <= 1'b0;
      result_q   <= '0;
      hi_q       <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cancel) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        if (cnt_q == 16'd1) begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          done_q   <= 1'b1;
          result_q <= res_pend_q;
          hi_q     <= hi_pend_q;
          ovf_q    <= ovf_pend_q;
        end else begin
          cnt_q <= cnt_q - 16'd1;
        end
      end else if (start) begin
        state_q    <= RUN;
        cnt_q      <= len_d;
        res_pend_q <= res_d;
        hi_pend_q  <= hi_d;
        ovf_pend_q <= ovf_d;
      end
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign result   = result_q;
  assign hi       = hi_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_iter_alu.sv
// tb/tb_iter_alu.sv - randomized and directed self-checking bench for iter_alu
module tb_iter_alu;

  logic        clk = 1'b0;
  logic        reset, start, cancel;
  logic [3:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done, overflow;
  logic [31:0] result, hi;
  int checks = 0;
  int failures = 0;

  iter_alu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .cancel(cancel), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .result(result), .hi(hi), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference built from plain 64-bit arithmetic on the operand values.
  function automatic void model(input logic [3:0] o, input logic [31:0] a, b,
                                output logic [31:0] r, h, output logic ov, output int lat);
    longint sa, sb, s, q, m;
    logic [63:0] p;
    logic [31:0] x;
    int n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0; h = 0; ov = 0; lat = 1;
    n = int'(b[4:0]);
    case (o)
      0: begin s = sa + sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      1: begin s = sa - sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      2: r = a & b;
      3: r = a | b;
      4: r = (sa < sb) ? 32'd1 : 32'd0;
      5: r = (a < b) ? 32'd1 : 32'd0;
      6: r = a << n;
      7: begin x = a; for (int i = 0; i < n; i++) x = {x[30:0], x[31]}; r = x; end
      8: begin x = a; for (int i = 0; i < n; i++) x = {x[0], x[31:1]}; r = x; end
      9: r = $countones(a);
      10: begin s = sa * sb; r = s[31:0]; h = s[63:32]; lat = 5; end
      11: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; h = p[63:32]; lat = 5; end
      12: begin
        lat = 10;
        if (b == 0) begin r = 32'hFFFFFFFF; h = a; end
        else begin q = sa / sb; m = sa % sb; r = q[31:0]; h = m[31:0]; end
      end
      13: begin
        lat = 10;
        if (b == 0) begin r = 32'hFFFFFFFF; h = a; end
        else begin r = a / b; h = a % b; end
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, b);
    logic [31:0] er, eh;
    logic eo;
    int el, nb;
    model(o, a, b, er, eh, eo, el);
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    checks++;
    if (nb != el || done !== 1'b1)
      $display("FAIL latency op=%0d busy_cycles=%0d done=%b exp_cycles=%0d exp_done=1", o, nb, done, el);
    checks++;
    if (result !== er) $display("FAIL result op=%0d a=%h b=%h got=%h exp=%h", o, a, b, result, er);
    if (result !== er) failures++;
    checks++;
    if (hi !== eh) $display("FAIL hi op=%0d a=%h b=%h got=%h exp=%h", o, a, b, hi, eh);
    if (hi !== eh) failures++;
    checks++;
    if (overflow !== eo) $display("FAIL overflow op=%0d a=%h b=%h got=%b exp=%b", o, a, b, overflow, eo);
    if (overflow !== eo) failures++;
    if (nb != el || done !== 1'b1) failures++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 0; src_a = 0; src_b = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, overflow, result, hi} !== 67'd0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b ovf=%b result=%h hi=%h exp=all_zero", busy, done, overflow, result, hi);
    end
  endtask

  task automatic test_directed();
    run_op(4'd0, 32'h7FFFFFFF, 32'h00000001);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== 32'h80000000) begin
      failures++;
      $display("FAIL done_pulse_hold done=%b result=%h exp_done=0 exp_result=80000000", done, result);
    end
    run_op(4'd1, 32'd5, 32'd7);
    run_op(4'd7, 32'h80000001, 32'd4);
    run_op(4'd8, 32'h00000018, 32'd4);
    run_op(4'd7, 32'h12345678, 32'd0);
    run_op(4'd8, 32'h12345678, 32'd32);
    run_op(4'd9, 32'hF0F0000F, 32'd0);
    run_op(4'd10, 32'hFFFFFFFF, 32'h00000002);
    run_op(4'd11, 32'hFFFFFFFF, 32'h00000002);
    run_op(4'd12, 32'hFFFFFFF9, 32'd2);
    run_op(4'd13, 32'd9, 32'd0);
    run_op(4'd12, 32'd9, 32'd0);
    run_op(4'd12, 32'h80000000, 32'hFFFFFFFF);
    run_op(4'd4, 32'hFFFFFFFF, 32'd1);
    run_op(4'd5, 32'hFFFFFFFF, 32'd1);
    run_op(4'd14, 32'hFFFFFFFF, 32'hFFFFFFFF);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [31:0] specials [4];
    specials[0] = 32'h0; specials[1] = 32'hFFFFFFFF; specials[2] = 32'h80000000; specials[3] = 32'h7FFFFFFF;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      run_op(4'($urandom_range(0, 15)), a, b);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] er, eh;
    logic eo;
    int el, nb;
    @(negedge clk);
    op = 4'd10; src_a = 32'hFFFFFFFF; src_b = 32'd2; start = 1'b1;
    @(negedge clk);
    op = 4'd0; src_a = 32'd100; src_b = 32'd23;
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    checks++;
    if (nb != 5 || done !== 1'b1 || result !== 32'hFFFFFFFE || hi !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL b2b_mult cycles=%0d done=%b result=%h hi=%h exp=5/1/fffffffe/ffffffff", nb, done, result, hi);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept busy=%b done=%b exp_busy=1 exp_done=0", busy, done);
    end
    model(4'd0, 32'd100, 32'd23, er, eh, eo, el);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || result !== er || hi !== eh) begin
      failures++;
      $display("FAIL b2b_add done=%b result=%h hi=%h exp_done=1 exp_result=%h exp_hi=%h", done, result, hi, er, eh);
    end
  endtask

  task automatic test_cancel();
    logic [31:0] pr, ph;
    logic po;
    int seen;
    run_op(4'd1, 32'h80000000, 32'd1);
    pr = result; ph = hi; po = overflow;
    @(negedge clk);
    op = 4'd12; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== pr || hi !== ph || overflow !== po) begin
      failures++;
      $display("FAIL cancel_state busy=%b done=%b result=%h hi=%h exp_busy=0 exp_done=0 exp_result=%h exp_hi=%h", busy, done, result, hi, pr, ph);
    end
    seen = 0;
    repeat (14) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL cancel_no_done pulses=%0d exp=0", seen);
    end
    start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL cancel_beats_start busy=%b exp=0", busy);
    end
  endtask

  task automatic test_reset_mid();
    run_op(4'd10, 32'hFFFFFFFF, 32'd2);
    @(negedge clk);
    op = 4'd10; src_a = 32'd7; src_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, overflow, result, hi} !== 67'd0) begin
      failures++;
      $display("FAIL reset_mid busy=%b done=%b ovf=%b result=%h hi=%h exp=all_zero", busy, done, overflow, result, hi);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_cancel();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
